// File: rtl/adain_lane_serializer_if.sv
// Handshake bundle between the 8-lane AdaIN datapath, the lane serializer and the narrow consumer.
// slave is the serializer side, master is the upstream/downstream environment side.
`timescale 1ns/1ps
interface adain_lane_serializer_if #(parameter int WIDTH = 16);
  logic               in_valid;
  logic               in_ready;
  logic [8*WIDTH-1:0] in_data;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   out_data;
  logic [2:0]         out_sel;
  logic               out_last;

  modport slave  (input  in_valid, in_data, out_ready,
                  output in_ready, out_valid, out_data, out_sel, out_last);
  modport master (output in_valid, in_data, out_ready,
                  input  in_ready, out_valid, out_data, out_sel, out_last);
endinterface

// File: rtl/adain_lane_serializer.sv
// Parallel-to-serial stage: captures eight WIDTH-bit lanes per handshake and streams them lane 0 first.
// Define ADAIN_SERIALIZER_PINGPONG_EN for two banks (A/B) that stream back-to-back without a bubble.
`timescale 1ns/1ps
module adain_lane_serializer #(
  parameter int WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  adain_lane_serializer_if.slave bus,
  output logic                   busy
);

  typedef enum logic {IDLE, STREAM} state_t;

  state_t     state, state_n;
  logic [2:0] sel, sel_n;
  logic       load, beat, last_beat;

  assign load      = bus.in_valid && bus.in_ready;
  assign beat      = bus.out_valid && bus.out_ready;
  assign last_beat = beat && (sel == 3'd7);

`ifdef ADAIN_SERIALIZER_PINGPONG_EN
  logic [WIDTH-1:0] bank [2][8];
  logic [1:0]       full, full_n;
  logic             rd, rd_n, wr;

  // A takes the load whenever it is empty; otherwise B must be the empty one.
  assign wr = full[0];

  always_ff @(posedge clk) begin
    if (load) begin
      for (int k = 0; k < 8; k++) bank[wr][k] <= bus.in_data[k*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    full_n = full;
    rd_n   = rd;
    sel_n  = sel;
    if (beat) sel_n = sel + 3'd1;
    if (last_beat) begin
      full_n[rd] = 1'b0;
      rd_n       = ~rd;
    end
    if (load) begin
      full_n[wr] = 1'b1;
      if (state == IDLE) begin
        rd_n  = wr;
        sel_n = 3'd0;
      end
    end
    state_n = full_n[rd_n] ? STREAM : IDLE;
  end

  assign bus.in_ready  = ~&full;
  assign bus.out_valid = (state == STREAM);
  assign bus.out_data  = bus.out_valid ? bank[rd][sel] : '0;
  assign busy          = (state != IDLE) || (|full);
`else
  logic [WIDTH-1:0] bank [8];

  always_ff @(posedge clk) begin
    if (load) begin
      for (int k = 0; k < 8; k++) bank[k] <= bus.in_data[k*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    state_n = state;
    sel_n   = sel;
    if (load) begin
      state_n = STREAM;
      sel_n   = 3'd0;
    end
    if (beat) begin
      sel_n = sel + 3'd1;
      if (sel == 3'd7) state_n = IDLE;
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == STREAM);
  assign bus.out_data  = bus.out_valid ? bank[sel] : '0;
  assign busy          = (state != IDLE);
`endif

  // Only control state is reset; bank contents are masked off while no vector is held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      sel   <= 3'd0;
`ifdef ADAIN_SERIALIZER_PINGPONG_EN
      full  <= 2'b00;
      rd    <= 1'b0;
`endif
    end else begin
      state <= state_n;
      sel   <= sel_n;
`ifdef ADAIN_SERIALIZER_PINGPONG_EN
      full  <= full_n;
      rd    <= rd_n;
`endif
    end
  end

  assign bus.out_sel  = sel;
  assign bus.out_last = bus.out_valid && (sel == 3'd7);

endmodule

// File: tb/tb_adain_lane_serializer.sv
// Directed and scoreboarded checks for adain_lane_serializer, in both bank configurations
// (ADAIN_SERIALIZER_PINGPONG_EN undefined or defined).
`timescale 1ns/1ps
module tb_adain_lane_serializer;
  localparam int WIDTH   = 16;
  localparam int MAX_CYC = 40000;

  logic clk = 1'b0;
  logic rst_n;
  logic busy;
  int   n_checks = 0;
  int   n_passed = 0;
  logic [WIDTH-1:0] exp_q [$];

  adain_lane_serializer_if #(.WIDTH(WIDTH)) bus ();

  adain_lane_serializer #(.WIDTH(WIDTH)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus),
    .busy (busy)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_passed++;
    else $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_vector(input logic [WIDTH-1:0] v [8]);
    for (int k = 0; k < 8; k++) bus.in_data[k*WIDTH +: WIDTH] = v[k];
    bus.in_valid = 1'b1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_output({tag, "_in_ready"},  bus.in_ready,  1);
    check_output({tag, "_out_valid"}, bus.out_valid, 0);
    check_output({tag, "_out_data"},  bus.out_data,  0);
    check_output({tag, "_out_sel"},   bus.out_sel,   0);
    check_output({tag, "_out_last"},  bus.out_last,  0);
    check_output({tag, "_busy"},      busy,          0);
  endtask

  task automatic check_beat(input string tag, input logic [WIDTH-1:0] data, input int lane);
    check_output({tag, "_valid"}, bus.out_valid, 1);
    check_output({tag, "_data"},  bus.out_data,  data);
    check_output({tag, "_sel"},   bus.out_sel,   lane);
    check_output({tag, "_last"},  bus.out_last,  (lane == 7));
  endtask

  // Offers nvec random vectors and scoreboards every beat; rnd randomises in_valid/out_ready.
  task automatic apply_stimulus(input int nvec, input bit rnd,
                                output int first_beat, output int last_beat, output int n_beats);
    logic [WIDTH-1:0] pend [8];
    int  sent;
    int  cyc;
    bit  accept;
    sent = 0;
    cyc = 0;
    n_beats = 0;
    first_beat = -1;
    last_beat = -1;
    exp_q.delete();
    bus.in_valid = 1'b0;
    while ((sent < nvec || exp_q.size() != 0) && cyc < MAX_CYC) begin
      if (!bus.in_valid && sent < nvec && (!rnd || $urandom_range(3) != 0)) begin
        for (int k = 0; k < 8; k++) pend[k] = WIDTH'($urandom);
        load_vector(pend);
      end
      bus.out_ready = rnd ? ($urandom_range(1) == 1) : 1'b1;
      check_output("sb_valid", bus.out_valid, (exp_q.size() != 0));
      accept = bus.in_valid && bus.in_ready;
      if (bus.out_valid && bus.out_ready && exp_q.size() != 0) begin
        check_output("sb_data", bus.out_data, exp_q[0]);
        check_output("sb_sel",  bus.out_sel,  n_beats % 8);
        check_output("sb_last", bus.out_last, (n_beats % 8 == 7));
        void'(exp_q.pop_front());
        if (first_beat < 0) first_beat = cyc;
        last_beat = cyc;
        n_beats++;
      end
      tick();
      cyc++;
      if (accept) begin
        for (int k = 0; k < 8; k++) exp_q.push_back(pend[k]);
        sent++;
        bus.in_valid = 1'b0;
      end
    end
    check_output("sb_timeout", (cyc < MAX_CYC), 1);
    bus.out_ready = 1'b0;
  endtask

  initial begin
    logic [WIDTH-1:0] vec  [8];
    logic [WIDTH-1:0] vec2 [8];
    int idx, cyc, first_b, last_b, nb;
    bit rdy;

    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("por");
    @(negedge clk) rst_n = 1'b1;
    tick();

    // Basic: lanes 0x0000..0x7777, first beat one cycle after load.
    for (int k = 0; k < 8; k++) vec[k] = WIDTH'(k * 'h1111);
    load_vector(vec);
    bus.out_ready = 1'b1;
    check_output("basic_in_ready", bus.in_ready, 1);
    tick();
    bus.in_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      check_beat("basic", vec[k], k);
      tick();
    end
    check_output("basic_end_valid", bus.out_valid, 0);
    check_output("basic_end_ready", bus.in_ready, 1);
    check_output("basic_end_busy",  busy, 0);

    // Backpressure: out_ready pattern 1,0,0 repeating; words must hold during stalls.
    for (int k = 0; k < 8; k++) vec[k] = WIDTH'('hB000 + k * 'h0101);
    load_vector(vec);
    tick();
    bus.in_valid = 1'b0;
    idx = 0;
    cyc = 0;
    while (idx < 8 && cyc < 100) begin
      rdy = (cyc % 3 == 0);
      bus.out_ready = rdy;
      check_beat("bp", vec[idx], idx);
      if (rdy) idx++;
      tick();
      cyc++;
    end
    check_output("bp_count", idx, 8);
    check_output("bp_end_valid", bus.out_valid, 0);

`ifndef ADAIN_SERIALIZER_PINGPONG_EN
    // Second vector held off until IDLE; it is captured 9 cycles after the first load.
    for (int k = 0; k < 8; k++) begin
      vec[k]  = WIDTH'('h5000 + k);
      vec2[k] = WIDTH'('hA000 + k);
    end
    load_vector(vec);
    bus.out_ready = 1'b1;
    tick();
    load_vector(vec2);
    for (int k = 0; k < 8; k++) begin
      check_output("hold_in_ready", bus.in_ready, 0);
      check_output("hold_data1", bus.out_data, vec[k]);
      tick();
    end
    check_output("hold_idle_ready", bus.in_ready, 1);
    check_output("hold_idle_valid", bus.out_valid, 0);
    tick();
    bus.in_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      check_beat("hold2", vec2[k], k);
      tick();
    end
`else
    // Second bank accepts the next vector at once and streams it right after lane 7.
    for (int k = 0; k < 8; k++) begin
      vec[k]  = WIDTH'('h5000 + k);
      vec2[k] = WIDTH'('hA000 + k);
    end
    load_vector(vec);
    bus.out_ready = 1'b1;
    tick();
    check_output("pp_second_ready", bus.in_ready, 1);
    load_vector(vec2);
    tick();
    bus.in_valid = 1'b0;
    check_output("pp_both_full", bus.in_ready, 0);
    for (int k = 1; k < 16; k++) begin
      check_beat("pp2", (k < 8) ? vec[k] : vec2[k-8], k % 8);
      tick();
    end
`endif
    check_output("seq_end_busy", busy, 0);

    // Reset mid-stream at sel=3.
    for (int k = 0; k < 8; k++) vec[k] = WIDTH'('h3000 + k);
    load_vector(vec);
    bus.out_ready = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    repeat (3) tick();
    check_output("mid_sel", bus.out_sel, 3);
    rst_n = 1'b0;
    #1 check_reset_outputs("mid_rst");
    @(negedge clk) rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      check_output("post_rst_valid", bus.out_valid, 0);
      check_output("post_rst_ready", bus.in_ready, 1);
    end

    // Three vectors back-to-back with out_ready high.
    apply_stimulus(3, 1'b0, first_b, last_b, nb);
    check_output("b2b_beats", nb, 24);
`ifdef ADAIN_SERIALIZER_PINGPONG_EN
    check_output("b2b_span", last_b - first_b, 23);
`else
    check_output("b2b_span", last_b - first_b, 25);
`endif

    // Random handshakes, 1000 vectors.
    apply_stimulus(1000, 1'b1, first_b, last_b, nb);
    check_output("rnd_beats", nb, 8000);
    check_output("rnd_end_busy", busy, 0);

    $display("%0d/%0d checks passed", n_passed, n_checks);
    $finish;
  end
endmodule
